// File: rtl/rxn_timer_ctrl.sv
// rxn_timer_ctrl: reaction-timer controller with button sync, ms tick, random arm delay and saturating count
module rxn_timer_ctrl #(
  parameter int          TICK_DIV  = 100000,
  parameter int          MIN_DELAY = 1000,
  parameter int          MAX_COUNT = 9999,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BTNC,
  input  logic        BTNL,
  output logic [15:0] value,
  output logic        blank,
  output logic        go_led,
  output logic        foul,
  output logic [2:0]  state
);
  localparam int          TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] MAXV = 16'(MAX_COUNT);
  localparam logic [15:0] MIND = 16'(MIN_DELAY);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FOUL  = 3'd4
  } state_t;
  state_t        state_q, state_d;
  logic [1:0]    s1_q, s2_q, prev_q, prev_d, rdy_q, rdy_d, ev;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [15:0]   lfsr_q, lfsr_d, delay_q, delay_d, value_q, value_d, value_inc, arm_delay;
  logic          tick, start_ev, stop_ev;
  // the edge detector stays blind until the synchronizers hold real samples, so a button held through reset never fires
  always_comb begin
    rdy_d  = (rdy_q == 2'd2) ? rdy_q : rdy_q + 2'd1;
    prev_d = (rdy_q == 2'd2) ? s2_q : 2'b11;
  end
  assign ev       = s2_q & ~prev_q;
  assign start_ev = ev[0];
  assign stop_ev  = ev[1];
  assign tick     = (tcnt_q == TW'(TICK_DIV - 1));
  assign tcnt_d   = tick ? '0 : tcnt_q + TW'(1);
  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign arm_delay = MIND + {5'd0, lfsr_q[10:0]};
  assign value_inc = value_q + 16'd1;
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    delay_d = delay_q;
    case (state_q)
      S_IDLE, S_DONE, S_FOUL: begin
        if (start_ev) begin
          state_d = S_ARMED;
          delay_d = arm_delay;
          value_d = '0;
        end
      end
      S_ARMED: begin
        if (stop_ev) begin
          state_d = S_FOUL;
          value_d = '0;
        end else if (tick && delay_q <= 16'd1) begin
          state_d = S_RUN;
          value_d = '0;
          delay_d = '0;
        end else if (tick) begin
          delay_d = delay_q - 16'd1;
        end
      end
      S_RUN: begin
        if (stop_ev) begin
          state_d = S_DONE;
        end else if (tick) begin
          value_d = (value_inc >= MAXV) ? MAXV : value_inc;
          state_d = (value_inc >= MAXV) ? S_DONE : S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        value_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= 2'b11;
      rdy_q   <= '0;
      tcnt_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      state_q <= S_IDLE;
      value_q <= '0;
      delay_q <= '0;
    end else begin
      s1_q    <= {BTNL, BTNC};
      s2_q    <= s1_q;
      prev_q  <= prev_d;
      rdy_q   <= rdy_d;
      tcnt_q  <= tcnt_d;
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      value_q <= value_d;
      delay_q <= delay_d;
    end
  end
  assign value  = value_q;
  assign blank  = (state_q == S_ARMED);
  assign go_led = (state_q == S_RUN);
  assign foul   = (state_q == S_FOUL);
  assign state  = state_q;
endmodule

// File: tb/tb_rxn_timer_ctrl.sv
// tb_rxn_timer_ctrl: directed checks of arming, timing, stop, foul, saturation and reset behaviour
module tb_rxn_timer_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  btn = '0;
  logic [15:0] v1, v2;
  logic        b1, g1, f1, b2, g2, f2;
  logic [2:0]  s1, s2;
  logic [15:0] m_lfsr;
  logic [1:0]  m_t;
  int          checks = 0;
  int          failures = 0;
  int          d;
  always #5 clk = ~clk;
  rxn_timer_ctrl #(.TICK_DIV(4), .MIN_DELAY(3)) dut (
    .clk(clk), .reset(reset), .BTNC(btn[0]), .BTNL(btn[1]),
    .value(v1), .blank(b1), .go_led(g1), .foul(f1), .state(s1)
  );
  rxn_timer_ctrl #(.TICK_DIV(4), .MIN_DELAY(3), .MAX_COUNT(10)) dut_sat (
    .clk(clk), .reset(reset), .BTNC(btn[2]), .BTNL(btn[3]),
    .value(v2), .blank(b2), .go_led(g2), .foul(f2), .state(s2)
  );
  // reference LFSR (x^16+x^14+x^13+x^11) and tick phase, both restarted by reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr <= 16'hACE1;
      m_t    <= 2'd0;
    end else begin
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_t    <= m_t + 2'd1;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge clk);
      if (m_t == 2'd3) k++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic press_start(input int b, output int dl);
    btn[b] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    dl = 3 + int'(m_lfsr[10:0]);
    @(posedge clk);
    #1;
    btn[b] = 1'b0;
  endtask
  task automatic press_stop(input int b);
    btn[b] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn[b] = 1'b0;
  endtask
  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("rst_state", 32'(s1), 0);
    chk("rst_value", 32'(v1), 0);
    chk("rst_blank", 32'(b1), 0);
    chk("rst_go", 32'(g1), 0);
    chk("rst_foul", 32'(f1), 0);
    chk("rst_state_sat", 32'(s2), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_state", 32'(s1), 0);
    press_start(0, d);
    chk("arm_state", 32'(s1), 1);
    chk("arm_blank", 32'(b1), 1);
    chk("arm_go", 32'(g1), 0);
    wait_ticks(d - 1);
    chk("armed_before_expiry", 32'(s1), 1);
    wait_ticks(1);
    chk("run_state", 32'(s1), 2);
    chk("run_go", 32'(g1), 1);
    chk("run_blank", 32'(b1), 0);
    chk("run_value0", 32'(v1), 0);
    wait_ticks(25);
    chk("run_value25", 32'(v1), 25);
    press_stop(1);
    chk("stop_state", 32'(s1), 3);
    chk("stop_value", 32'(v1), 25);
    chk("stop_go", 32'(g1), 0);
    repeat (100) @(posedge clk);
    #1;
    chk("done_hold_value", 32'(v1), 25);
    chk("done_hold_state", 32'(s1), 3);
    press_start(0, d);
    chk("rearm_state", 32'(s1), 1);
    press_stop(1);
    chk("foul_state", 32'(s1), 4);
    chk("foul_flag", 32'(f1), 1);
    chk("foul_value", 32'(v1), 0);
    chk("foul_blank", 32'(b1), 0);
    chk("foul_go", 32'(g1), 0);
    repeat (2) @(posedge clk);
    #1;
    press_start(0, d);
    chk("foul_rearm_state", 32'(s1), 1);
    chk("foul_rearm_flag", 32'(f1), 0);
    chk("foul_rearm_blank", 32'(b1), 1);
    wait_ticks(d);
    chk("run2_state", 32'(s1), 2);
    wait_ticks(7);
    chk("run2_value7", 32'(v1), 7);
    @(posedge clk);
    #1;
    press_stop(1);
    chk("tick_stop_value", 32'(v1), 7);
    chk("tick_stop_state", 32'(s1), 3);
    wait_ticks(2);
    chk("tick_stop_hold", 32'(v1), 7);
    press_start(2, d);
    chk("sat_arm_state", 32'(s2), 1);
    wait_ticks(d);
    chk("sat_run_state", 32'(s2), 2);
    wait_ticks(9);
    chk("sat_value9", 32'(v2), 9);
    chk("sat_state9", 32'(s2), 2);
    wait_ticks(1);
    chk("sat_value10", 32'(v2), 10);
    chk("sat_done", 32'(s2), 3);
    wait_ticks(3);
    chk("sat_never_11", 32'(v2), 10);
    press_start(0, d);
    wait_ticks(d);
    chk("run3_state", 32'(s1), 2);
    wait_ticks(5);
    chk("run3_value5", 32'(v1), 5);
    btn[0] = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(s1), 0);
    chk("async_rst_value", 32'(v1), 0);
    chk("async_rst_go", 32'(g1), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("held_btn_no_arm", 32'(s1), 0);
    chk("held_btn_blank", 32'(b1), 0);
    btn[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    press_start(0, d);
    chk("new_press_arm", 32'(s1), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
